// File: rtl/sc_stream_gen.sv
// sc_stream_gen: binary-to-stochastic stream generator.
// Emits 2^WIDTH bits holding exactly `value` ones, from a maximal-length
// Fibonacci LFSR compared against the latched magnitude.
module sc_stream_gen #(
    parameter int          WIDTH = 8,
    parameter int unsigned SEED  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    input  logic             hold,
    output logic             busy,
    output logic             bit_valid,
    output logic             bit_out,
    output logic             done
);

    // Feedback tap masks (tap n drives from bit n-1), one maximal-length set per width.
    function automatic logic [15:0] tap_mask(input int w);
        logic [15:0] m;
        case (w)
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0E08;
            13:      m = 16'h1C80;
            14:      m = 16'h3802;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h00B8;
        endcase
        return m;
    endfunction

    localparam logic [WIDTH-1:0] TAPS     = WIDTH'(tap_mask(WIDTH));
    localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] LAST_IDX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] val_q, val_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             bit_valid_q, bit_valid_d;
    logic             bit_out_q, bit_out_d;
    logic             done_q, done_d;

    // r sweeps 0..2^WIDTH-2 once per LFSR period, so (r < val) yields exactly
    // val ones in the first 2^WIDTH-1 bits; the final bit is forced to 0.
    logic [WIDTH-1:0] r;
    logic             fb;
    logic             last_bit;

    assign r        = lfsr_q - WIDTH'(1);
    assign fb       = ^(lfsr_q & TAPS);
    assign last_bit = (idx_q == LAST_IDX);

    // Next-state and registered-output logic for the IDLE/RUN machine.
    always_comb begin
        state_d     = state_q;
        val_d       = val_q;
        lfsr_d      = lfsr_q;
        idx_d       = idx_q;
        busy_d      = (state_q == RUN);
        bit_valid_d = 1'b0;
        bit_out_d   = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    val_d   = value;
                    lfsr_d  = SEED_W;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!hold) begin
                    bit_valid_d = 1'b1;
                    bit_out_d   = last_bit ? 1'b0 : (r < val_q);
                    done_d      = last_bit;
                    lfsr_d      = {lfsr_q[WIDTH-2:0], fb};
                    // idx wraps to 0 on the last bit, leaving it ready for the next stream.
                    idx_d       = idx_q + WIDTH'(1);
                    if (last_bit) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any stream in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            val_q       <= '0;
            lfsr_q      <= SEED_W;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            val_q       <= val_d;
            lfsr_q      <= lfsr_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            bit_valid_q <= bit_valid_d;
            bit_out_q   <= bit_out_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign bit_valid = bit_valid_q;
    assign bit_out   = bit_out_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sc_stream_gen.sv
// Testbench for sc_stream_gen (WIDTH=8, SEED=1): a scoreboard queue of
// expected stream bits is filled when a start is accepted and drained as
// valid bits appear.
module tb_sc_stream_gen;

    localparam int WIDTH = 8;
    localparam int LEN   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] value;
    logic             hold;
    logic             busy;
    logic             bit_valid;
    logic             bit_out;
    logic             done;

    sc_stream_gen #(.WIDTH(WIDTH), .SEED(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .value     (value),
        .hold      (hold),
        .busy      (busy),
        .bit_valid (bit_valid),
        .bit_out   (bit_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard / reference model state
    bit          exp_q[$];
    bit          model_run  = 1'b0;
    int          model_val  = 0;
    int          ones       = 0;
    int          bit_idx    = 0;
    int          holds      = 0;
    int          cyc        = 0;
    int          start_cyc  = 0;
    int          stream_no  = 0;

    // Reference: Fibonacci LFSR with taps 8,6,5,4, compared as (lfsr-1) < value.
    task automatic push_stream(input int v);
        logic [7:0] l;
        logic [7:0] r;
        l = 8'd1;
        for (int i = 0; i < LEN; i++) begin
            r = l - 8'd1;
            exp_q.push_back((i == LEN - 1) ? 1'b0 : (int'(r) < v));
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
    endtask

    // Monitor: samples just after every rising edge.
    always @(posedge clk) begin
        bit run_before;
        bit exp_v;
        bit e;
        #1;
        cyc++;
        run_before = model_run;
        if (rst) begin
            check("rst_busy", busy, 0);
            check("rst_bit_valid", bit_valid, 0);
            check("rst_bit_out", bit_out, 0);
            check("rst_done", done, 0);
            exp_q.delete();
            model_run = 1'b0;
        end else begin
            check("busy", busy, run_before);
            exp_v = run_before && !hold;
            check("bit_valid", bit_valid, exp_v);
            if (exp_v) begin
                e = exp_q.pop_front();
                check("bit_out", bit_out, e);
                bit_idx++;
                ones += int'(bit_out);
                check("done", done, (exp_q.size() == 0));
                if (exp_q.size() == 0) begin
                    check("ones_count", ones, model_val);
                    check("done_cycle", cyc - start_cyc, LEN + holds);
                    $display("stream %0d value=%0d ones=%0d holds=%0d len_cycles=%0d",
                             stream_no, model_val, ones, holds, cyc - start_cyc);
                    model_run = 1'b0;
                end
            end else begin
                check("bit_out_idle", bit_out, 0);
                check("done_idle", done, 0);
                if (run_before && hold) holds++;
            end
            if (!run_before && start) begin
                exp_q.delete();
                push_stream(int'(value));
                model_val = int'(value);
                model_run = 1'b1;
                ones      = 0;
                bit_idx   = 0;
                holds     = 0;
                start_cyc = cyc;
                stream_no++;
            end
        end
    end

    task automatic pulse_start(input int v);
        @(negedge clk);
        start = 1'b1;
        value = WIDTH'(v);
        @(negedge clk);
        start = 1'b0;
        value = WIDTH'($urandom);
    endtask

    task automatic wait_idle(input bit rand_hold);
        int guard;
        guard = 0;
        while (model_run && guard < 4000) begin
            @(negedge clk);
            hold = rand_hold ? ($urandom_range(0, 99) < 30) : 1'b0;
            guard++;
        end
        hold = 1'b0;
        if (model_run) check("timeout_idle", 0, 1);
    endtask

    task automatic wait_bits(input int n);
        int guard;
        guard = 0;
        while (bit_idx < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (bit_idx < n) check("timeout_bits", bit_idx, n);
    endtask

    task automatic run_stream(input int v, input bit rand_hold);
        pulse_start(v);
        wait_idle(rand_hold);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        value = '0;
        hold  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Plain streams across the value range
        run_stream(0, 1'b0);
        run_stream(255, 1'b0);
        run_stream(100, 1'b0);
        run_stream(1, 1'b0);
        run_stream(128, 1'b0);
        run_stream(200, 1'b0);

        // Random stalls: same sequence, done delayed by the stall count
        run_stream(100, 1'b1);

        // Starts during RUN are ignored; start right after done is accepted
        pulse_start(77);
        wait_bits(10);
        start = 1'b1;
        value = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_bits(200);
        start = 1'b1;
        value = 8'd9;
        @(negedge clk);
        start = 1'b0;
        wait_idle(1'b0);
        start = 1'b1;
        value = 8'd50;
        @(negedge clk);
        start = 1'b0;
        check("start_after_done_accepted", int'(model_run), 1);
        wait_idle(1'b0);

        // Reset in the middle of a stream, then a fresh full stream
        pulse_start(60);
        wait_bits(50);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_aborts_model", int'(model_run), 0);
        repeat (2) @(negedge clk);
        run_stream(60, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
